// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer scheduler: FSM states, bank selects,
// engine indices and a small state-to-engine decode helper.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0K0 = 3'd1,
    S_L0K1 = 3'd2,
    S_L1K0 = 3'd3,
    S_L1K1 = 3'd4,
    S_L2   = 3'd5,
    S_FIN  = 3'd6
  } sched_state_t;

  // Layer-memory bank selects
  localparam logic [2:0] CSEL_IMG  = 3'd0;
  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2   = 3'd5;

  // Engine indices (bit positions in eng_start / eng_done)
  localparam int ENG_L0 = 0;
  localparam int ENG_L1 = 1;
  localparam int ENG_L2 = 2;

  // One-hot mask of the engine that owns the given state (zero outside a pass)
  function automatic logic [2:0] eng_onehot(input sched_state_t s);
    case (s)
      S_L0K0, S_L0K1: return 3'b001 << ENG_L0;
      S_L1K0, S_L1K1: return 3'b001 << ENG_L1;
      S_L2:           return 3'b001 << ENG_L2;
      default:        return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cnn_port_mux.sv
// Shared layer-memory port mux: forwards only the active engine's requests,
// derives the bank select, and flags requests that must be dropped.
module cnn_port_mux
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
) (
  input  sched_state_t      state,
  input  logic              e0_cwr,
  input  logic              e0_crd,
  input  logic [ADDR_W-1:0] e0_caddr_wr,
  input  logic [ADDR_W-1:0] e0_caddr_rd,
  input  logic [DATA_W-1:0] e0_cdata_wr,
  input  logic              e1_cwr,
  input  logic              e1_crd,
  input  logic [ADDR_W-1:0] e1_caddr_wr,
  input  logic [ADDR_W-1:0] e1_caddr_rd,
  input  logic [DATA_W-1:0] e1_cdata_wr,
  input  logic              e2_cwr,
  input  logic              e2_crd,
  input  logic [ADDR_W-1:0] e2_caddr_wr,
  input  logic [ADDR_W-1:0] e2_caddr_rd,
  input  logic [DATA_W-1:0] e2_cdata_wr,
  input  logic              e2_rbank,
  output logic              cwr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel,
  output logic              req_err
);

  logic              act_wr;
  logic              act_rd;
  logic [ADDR_W-1:0] act_aw;
  logic [ADDR_W-1:0] act_ar;
  logic [DATA_W-1:0] act_d;
  logic              other_req;
  logic [2:0]        wr_bank;
  logic [2:0]        rd_bank;

  // Select the active engine's request set and its bank pair from the state
  always_comb begin
    act_wr    = 1'b0;
    act_rd    = 1'b0;
    act_aw    = '0;
    act_ar    = '0;
    act_d     = '0;
    other_req = 1'b0;
    wr_bank   = CSEL_IMG;
    rd_bank   = CSEL_IMG;
    case (state)
      S_L0K0, S_L0K1: begin
        act_wr    = e0_cwr;
        act_rd    = e0_crd;
        act_aw    = e0_caddr_wr;
        act_ar    = e0_caddr_rd;
        act_d     = e0_cdata_wr;
        other_req = e1_cwr | e1_crd | e2_cwr | e2_crd;
        wr_bank   = (state == S_L0K0) ? CSEL_L0K0 : CSEL_L0K1;
        rd_bank   = CSEL_IMG;
      end
      S_L1K0, S_L1K1: begin
        act_wr    = e1_cwr;
        act_rd    = e1_crd;
        act_aw    = e1_caddr_wr;
        act_ar    = e1_caddr_rd;
        act_d     = e1_cdata_wr;
        other_req = e0_cwr | e0_crd | e2_cwr | e2_crd;
        wr_bank   = (state == S_L1K0) ? CSEL_L1K0 : CSEL_L1K1;
        rd_bank   = (state == S_L1K0) ? CSEL_L0K0 : CSEL_L0K1;
      end
      S_L2: begin
        act_wr    = e2_cwr;
        act_rd    = e2_crd;
        act_aw    = e2_caddr_wr;
        act_ar    = e2_caddr_rd;
        act_d     = e2_cdata_wr;
        other_req = e0_cwr | e0_crd | e1_cwr | e1_crd;
        wr_bank   = CSEL_L2;
        rd_bank   = e2_rbank ? CSEL_L1K1 : CSEL_L1K0;
      end
      default: ;
    endcase
  end

  // Drive the shared port; a write suppresses a simultaneous read
  always_comb begin
    cwr      = act_wr;
    crd      = act_rd & ~act_wr;
    caddr_wr = act_aw;
    caddr_rd = act_ar;
    cdata_wr = act_d;
    if (act_wr)      csel = wr_bank;
    else if (act_rd) csel = rd_bank;
    else             csel = CSEL_IMG;
    req_err  = other_req | (act_wr & act_rd);
  end

endmodule

// File: rtl/cnn_layer_sched.sv
// CNN layer sequencer: runs L0K0, L0K1, L1K0, L1K1, L2 in order with
// start/done handshakes, owns the shared layer-memory port, and aborts a
// pass that runs past the watchdog limit.
// Engine handshake: eng_start[x] is a one-cycle pulse on pass entry; the
// pass completes on the first eng_done[x] pulse at least one cycle later.
module cnn_layer_sched
  import cnn_pkg::*;
#(
  parameter logic [31:0] WDOG_CYC = 32'd200000,
  parameter int          ADDR_W   = 12,
  parameter int          DATA_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic              err,
  output logic [2:0]        eng_start,
  output logic              eng_ksel,
  input  logic [2:0]        eng_done,
  input  logic              e0_cwr,
  input  logic              e0_crd,
  input  logic [ADDR_W-1:0] e0_caddr_wr,
  input  logic [ADDR_W-1:0] e0_caddr_rd,
  input  logic [DATA_W-1:0] e0_cdata_wr,
  input  logic              e1_cwr,
  input  logic              e1_crd,
  input  logic [ADDR_W-1:0] e1_caddr_wr,
  input  logic [ADDR_W-1:0] e1_caddr_rd,
  input  logic [DATA_W-1:0] e1_cdata_wr,
  input  logic              e2_cwr,
  input  logic              e2_crd,
  input  logic [ADDR_W-1:0] e2_caddr_wr,
  input  logic [ADDR_W-1:0] e2_caddr_rd,
  input  logic [DATA_W-1:0] e2_cdata_wr,
  input  logic              e2_rbank,
  output logic              cwr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel,
  output logic [2:0]        dbg_state
);

  sched_state_t state;
  logic [31:0]  wdog;
  logic [2:0]   act_oh;
  logic         act_done;
  logic         stray_done;
  logic         req_err;

  // Done decode against the engine owning the current pass
  always_comb begin
    act_oh     = eng_onehot(state);
    act_done   = |(eng_done & act_oh);
    stray_done = |(eng_done & ~act_oh);
    dbg_state  = state;
  end

  cnn_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .state       (state),
    .e0_cwr      (e0_cwr),
    .e0_crd      (e0_crd),
    .e0_caddr_wr (e0_caddr_wr),
    .e0_caddr_rd (e0_caddr_rd),
    .e0_cdata_wr (e0_cdata_wr),
    .e1_cwr      (e1_cwr),
    .e1_crd      (e1_crd),
    .e1_caddr_wr (e1_caddr_wr),
    .e1_caddr_rd (e1_caddr_rd),
    .e1_cdata_wr (e1_cdata_wr),
    .e2_cwr      (e2_cwr),
    .e2_crd      (e2_crd),
    .e2_caddr_wr (e2_caddr_wr),
    .e2_caddr_rd (e2_caddr_rd),
    .e2_cdata_wr (e2_cdata_wr),
    .e2_rbank    (e2_rbank),
    .cwr         (cwr),
    .crd         (crd),
    .caddr_wr    (caddr_wr),
    .caddr_rd    (caddr_rd),
    .cdata_wr    (cdata_wr),
    .csel        (csel),
    .req_err     (req_err)
  );

  // Pass sequencer with watchdog, busy and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      eng_start <= 3'b000;
      eng_ksel  <= 1'b0;
      wdog      <= 32'd0;
    end else begin
      eng_start <= 3'b000;
      case (state)
        S_IDLE: begin
          if (ready) begin
            state     <= S_L0K0;
            busy      <= 1'b1;
            err       <= 1'b0;
            eng_start <= 3'b001;
            eng_ksel  <= 1'b0;
            wdog      <= 32'd0;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          if (req_err || stray_done) err <= 1'b1;
          // wdog is zero only in the start cycle, where done is ignored
          if (act_done && (wdog != 32'd0)) begin
            wdog <= 32'd0;
            case (state)
              S_L0K0: begin state <= S_L0K1; eng_start <= 3'b001; eng_ksel <= 1'b1; end
              S_L0K1: begin state <= S_L1K0; eng_start <= 3'b010; eng_ksel <= 1'b0; end
              S_L1K0: begin state <= S_L1K1; eng_start <= 3'b010; eng_ksel <= 1'b1; end
              S_L1K1: begin state <= S_L2;   eng_start <= 3'b100; eng_ksel <= 1'b0; end
              default: begin state <= S_FIN; eng_ksel <= 1'b0; end
            endcase
          end else if (wdog == (WDOG_CYC - 32'd1)) begin
            err      <= 1'b1;
            state    <= S_FIN;
            eng_ksel <= 1'b0;
            wdog     <= 32'd0;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Bench for cnn_layer_sched: directed jobs plus randomized jobs, checked
// against a pass-table model of the sequencer and the shared-port mapping.
module tb_cnn_layer_sched;

  localparam int AW   = 12;
  localparam int DW   = 20;
  localparam int WDOG = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic ready;
  logic [2:0] eng_done;
  logic e_cwr [3];
  logic e_crd [3];
  logic [AW-1:0] e_aw [3];
  logic [AW-1:0] e_ar [3];
  logic [DW-1:0] e_d [3];
  logic e2_rbank;

  logic busy, err, eng_ksel, cwr, crd;
  logic [2:0] eng_start, csel, dbg_state;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;

  always #5 clk = ~clk;

  cnn_layer_sched #(
    .WDOG_CYC (32'd16),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .busy        (busy),
    .err         (err),
    .eng_start   (eng_start),
    .eng_ksel    (eng_ksel),
    .eng_done    (eng_done),
    .e0_cwr      (e_cwr[0]),
    .e0_crd      (e_crd[0]),
    .e0_caddr_wr (e_aw[0]),
    .e0_caddr_rd (e_ar[0]),
    .e0_cdata_wr (e_d[0]),
    .e1_cwr      (e_cwr[1]),
    .e1_crd      (e_crd[1]),
    .e1_caddr_wr (e_aw[1]),
    .e1_caddr_rd (e_ar[1]),
    .e1_cdata_wr (e_d[1]),
    .e2_cwr      (e_cwr[2]),
    .e2_crd      (e_crd[2]),
    .e2_caddr_wr (e_aw[2]),
    .e2_caddr_rd (e_ar[2]),
    .e2_cdata_wr (e_d[2]),
    .e2_rbank    (e2_rbank),
    .cwr         (cwr),
    .crd         (crd),
    .caddr_wr    (caddr_wr),
    .caddr_rd    (caddr_rd),
    .cdata_wr    (cdata_wr),
    .csel        (csel),
    .dbg_state   (dbg_state)
  );

  // ---------------- model state ----------------
  int pass_eng [5] = '{0, 0, 1, 1, 2};
  int pass_k   [5] = '{0, 1, 0, 1, 0};
  int checks = 0;
  int errors = 0;
  bit exp_err  = 1'b0;
  bit pend_err = 1'b0;
  bit iso_test = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      e_cwr[i] = 1'b0; e_crd[i] = 1'b0;
      e_aw[i] = '0; e_ar[i] = '0; e_d[i] = '0;
    end
    eng_done = 3'b000;
    e2_rbank = 1'b0;
  endtask

  // Random memory traffic for pass p, cycle c; records expected error causes
  task automatic drive_reqs(input int p, input bit noisy, input int c);
    int a, mode, o;
    for (int i = 0; i < 3; i++) begin
      e_cwr[i] = 1'b0; e_crd[i] = 1'b0;
      e_aw[i] = AW'($urandom); e_ar[i] = AW'($urandom); e_d[i] = DW'($urandom);
    end
    e2_rbank = 1'($urandom);
    eng_done = 3'b000;
    a = pass_eng[p];
    mode = noisy ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
    e_cwr[a] = (mode >= 2);
    e_crd[a] = (mode == 1 || mode == 3);
    if (mode == 3) pend_err = 1'b1;
    if (!noisy && p == 0 && c == 1) begin
      e_cwr[0] = 1'b1; e_crd[0] = 1'b0;
      e_aw[0] = 12'h0FF; e_d[0] = 20'h12345;
    end
    if (iso_test && p == 1 && c == 1) begin
      e_cwr[0] = 1'b0; e_crd[0] = 1'b0; e_cwr[1] = 1'b1;
      pend_err = 1'b1;
    end
    if (noisy && $urandom_range(0, 4) == 0) begin
      o = (a + int'($urandom_range(1, 2))) % 3;
      if ($urandom_range(0, 1) == 1) e_cwr[o] = 1'b1; else e_crd[o] = 1'b1;
      pend_err = 1'b1;
    end
    if (noisy && $urandom_range(0, 5) == 0) begin
      o = (a + int'($urandom_range(1, 2))) % 3;
      eng_done[o] = 1'b1;
      pend_err = 1'b1;
    end
  endtask

  // Expected shared-port outputs; p < 0 means no pass is active
  task automatic check_port(input int p);
    logic w, r;
    logic [2:0] cs, wb, rb;
    logic [AW-1:0] aw, ar;
    logic [DW-1:0] d;
    int a, k;
    w = 1'b0; r = 1'b0; cs = 3'd0; aw = '0; ar = '0; d = '0;
    if (p >= 0) begin
      a = pass_eng[p];
      k = pass_k[p];
      w = e_cwr[a];
      r = e_crd[a] && !w;
      aw = e_aw[a]; ar = e_ar[a]; d = e_d[a];
      wb = 3'(2 * a + k + 1);
      rb = (a == 0) ? 3'd0 : (a == 1) ? 3'(1 + k) : 3'(3 + int'(e2_rbank));
      cs = w ? wb : (r ? rb : 3'd0);
    end
    chk("cwr", 32'(cwr), 32'(w));
    chk("crd", 32'(crd), 32'(r));
    chk("caddr_wr", 32'(caddr_wr), 32'(aw));
    chk("caddr_rd", 32'(caddr_rd), 32'(ar));
    chk("cdata_wr", 32'(cdata_wr), 32'(d));
    chk("csel", 32'(csel), 32'(cs));
  endtask

  task automatic idle_cycles(input int n);
    ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      exp_err |= pend_err; pend_err = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_err", 32'(err), 32'(exp_err));
      chk("idle_start", 32'(eng_start), 32'd0);
      clear_inputs();
      #1;
      check_port(-1);
    end
  endtask

  // One job: fixed_d > 0 fixes the done delay; hang_p names a pass whose
  // engine never finishes; rst_p names a pass hit by reset; chain keeps
  // ready high through FIN so the next job starts right after.
  task automatic run_job(input int fixed_d, input bit noisy, input int hang_p,
                         input bit early, input int rst_p, input bit chain);
    int d, a;
    bit hung;
    hung = 1'b0;
    ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      a = pass_eng[p];
      d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, WDOG - 2));
      for (int c = 0; c < WDOG; c++) begin
        tick();
        if (p == 0 && c == 0) begin
          ready = 1'b0; exp_err = 1'b0; pend_err = 1'b0;
        end else begin
          exp_err |= pend_err; pend_err = 1'b0;
        end
        chk("busy", 32'(busy), 32'd1);
        chk("err", 32'(err), 32'(exp_err));
        chk("eng_start", 32'(eng_start), (c == 0) ? 32'(1 << a) : 32'd0);
        chk("eng_ksel", 32'(eng_ksel), 32'(pass_k[p]));
        drive_reqs(p, noisy, c);
        if (p == hang_p) begin
          if (c == WDOG - 1) begin hung = 1'b1; pend_err = 1'b1; end
        end else if (c == d) begin
          eng_done[a] = 1'b1;
        end
        if (early && c == 0) eng_done[a] = 1'b1;
        if (p == rst_p && c == 2) begin
          for (int i = 0; i < 3; i++) begin e_cwr[i] = 1'b0; e_crd[i] = 1'b0; end
          e_cwr[1] = 1'b1;
          eng_done = 3'b000;
          #1;
          check_port(p);
          reset = 1'b1;
          #1;
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_cwr", 32'(cwr), 32'd0);
          chk("rst_csel", 32'(csel), 32'd0);
          chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
          chk("rst_start", 32'(eng_start), 32'd0);
          tick();
          reset = 1'b0;
          exp_err = 1'b0; pend_err = 1'b0;
          clear_inputs();
          idle_cycles(4);
          return;
        end
        #1;
        check_port(p);
        if (hung || (p != hang_p && c == d)) break;
      end
      if (hung) break;
    end
    // FIN
    tick();
    clear_inputs();
    ready = chain;
    exp_err |= pend_err; pend_err = 1'b0;
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_err", 32'(err), 32'(exp_err));
    chk("fin_start", 32'(eng_start), 32'd0);
    #1;
    check_port(-1);
    // back in IDLE
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_start", 32'(eng_start), 32'd0);
    check_port(-1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    ready = 1'b0;
    clear_inputs();
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_start", 32'(eng_start), 32'd0);
    chk("reset_ksel", 32'(eng_ksel), 32'd0);
    check_port(-1);
    #5;
    reset = 1'b0;
    idle_cycles(3);

    // nominal job, done 10 cycles after each start, clean traffic
    run_job(10, 1'b0, -1, 1'b0, -1, 1'b0);
    idle_cycles(2);

    // done in the start cycle ignored; isolation fault in L0K1 makes err sticky
    iso_test = 1'b1;
    run_job(3, 1'b0, -1, 1'b1, -1, 1'b0);
    iso_test = 1'b0;
    idle_cycles(3);

    // watchdog in L0K0: no further starts, err held in IDLE
    run_job(0, 1'b0, 0, 1'b0, -1, 1'b0);
    idle_cycles(5);

    // ready held through FIN: next job starts after a one-cycle gap
    run_job(4, 1'b0, -1, 1'b0, -1, 1'b1);
    run_job(0, 1'b0, -1, 1'b0, -1, 1'b0);
    idle_cycles(2);

    // randomized jobs with noisy traffic, early dones and occasional hangs
    for (int i = 0; i < 8; i++) begin
      run_job(0, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
              1'($urandom_range(0, 1)), -1,
              (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    idle_cycles(2);

    // reset in the middle of L1K0 while engine 1 writes
    run_job(2, 1'b0, -1, 1'b0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sched.md
Name: cnn_layer_sched

Overview:
- Top-level sequencer for the CNN accelerator. It runs the conv (L0), max-pool (L1) and flatten (L2) engines in a fixed pass order using start/done handshakes.
- It owns the single shared layer-memory port: it forwards only the active engine's requests and drives csel itself.
- It handles the host ready/busy handshake and aborts any pass that exceeds a watchdog limit.

Parameters:
- WDOG_CYC, 32'd200000, maximum cycles allowed per pass before abort.
- ADDR_W, 12, layer-memory address width.
- DATA_W, 20, layer-memory data width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ready  in  1  host: input image loaded, start job
- busy  out  1  high from job accept until the job ends
- err  out  1  sticky error flag, cleared only by the next accepted job or by reset
- eng_start  out  3  one-hot one-cycle start pulse; bit0 = L0, bit1 = L1, bit2 = L2
- eng_ksel  out  1  kernel/channel index for the current pass
- eng_done  in  3  per-engine one-cycle done pulse
- eN_cwr, eN_crd (N=0..2)  in  1 each  engine write/read request
- eN_caddr_wr, eN_caddr_rd  in  ADDR_W each  engine addresses
- eN_cdata_wr  in  DATA_W  engine write data
- e2_rbank  in  1  L2 read-bank select: 0 = bank 3, 1 = bank 4
- cwr, crd  out  1  shared-port write/read strobes
- caddr_wr, caddr_rd  out  ADDR_W  shared-port addresses
- cdata_wr  out  DATA_W  shared-port write data
- csel  out  3  shared-port bank select

Behaviour:
- FSM states: IDLE, L0K0, L0K1, L1K0, L1K1, L2, FIN.
- Reset values: state IDLE, busy 0, err 0, eng_start 0, eng_ksel 0, watchdog counter 0.
- IDLE:
  - ready sampled 1 -> go to L0K0.
  - busy rises and err clears on that same clock edge.
  - ready is ignored in all other states.
- Pass entry:
  - On the edge that enters Lx state, eng_start[x] is 1 for exactly one cycle, and eng_ksel is registered.
  - eng_ksel = 0 for K0 and L2, 1 for K1.
- Pass completion:
  - The pass ends on eng_done[x]=1 when the active engine is x and the pass is at least 1 cycle after start.
  - A done asserted in the start cycle is ignored.
  - Done pulses from inactive engines are ignored and set err.
- Pass order: L0K0 -> L0K1 -> L1K0 -> L1K1 -> L2 -> FIN -> IDLE.
  - The next pass's start pulse is issued on the edge that leaves the previous pass.
  - Done-to-next-start latency is 1 cycle.
- FIN: lasts 1 cycle; busy clears on the edge FIN -> IDLE.
- Watchdog:
  - The counter resets on every pass entry and increments each cycle while in a pass.
  - Reaching WDOG_CYC-1 without done sets err and goes to FIN. Remaining passes are skipped and no start is issued.
- Port forwarding (combinational, zero latency):
  - Only the active engine's cwr/crd/addresses/data are forwarded.
  - In IDLE/FIN, cwr=crd=0 and addresses/data are 0.
  - An inactive engine asserting cwr or crd sets err; its request is dropped.
- csel:
  - If forwarded cwr=1: write bank.
    - L0Kk -> 1+k
    - L1Kk -> 3+k
    - L2 -> 5
  - Else if forwarded crd=1: read bank.
    - L0 -> 0
    - L1Kk -> 1+k
    - L2 -> 3+e2_rbank
  - Else csel=0.
  - Active engine asserting cwr and crd in the same cycle: write wins, crd forced 0, err set.
- Reset mid-job: returns to IDLE immediately, with busy=0 and all strobes 0. No start pulse is issued on reset release.
- ready held high through FIN starts a new job from IDLE on the next cycle, with a 1-cycle idle gap in busy.

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum;
  - bank constants CSEL_IMG=0, CSEL_L0K0=1, CSEL_L0K1=2, CSEL_L1K0=3, CSEL_L1K1=4, CSEL_L2=5;
  - engine index constants ENG_L0/L1/L2.
- Sub-module cnn_port_mux: combinational forward/csel/error-detect logic, driven by the state and engine request buses.
- The FSM, watchdog and busy logic stay in the top.

Test Plan:
- Nominal job: ready pulse at cycle 5, then each engine asserts done 10 cycles after its start.
  - busy=1 from cycle 6.
  - Starts observed in order 001,001,010,010,100 with eng_ksel 0,1,0,1,0.
  - busy falls 2 cycles after the L2 done; err=0.
- csel mapping:
  - L1K1 active, e1_crd=1 -> csel=2.
  - L1K1 active, e1_cwr=1 -> csel=4.
  - L2 with e2_rbank=1 and crd -> csel=4.
  - L2 write -> csel=5.
  - L0K0 write addr 12'h0FF data 20'h12345 -> appears on caddr_wr/cdata_wr in the same cycle.
- Isolation: in L0K1, e1_cwr=1 with e0 idle -> cwr=0 and err=1. err stays 1 until the next ready is accepted.
- Watchdog: WDOG_CYC=16, engine L0 never asserts done in L0K0.
  - err=1 after 16 cycles, followed by FIN, then busy=0.
  - No further eng_start pulses.
- Early/late done: eng_done[0] in the same cycle as start is ignored, so the pass continues; done asserted 3 cycles later advances to L0K1.
- Reset mid-L1K0 while e1_cwr=1: outputs go to 0 asynchronously; after release the block stays in IDLE with busy=0 until ready.
